serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller. Two WIDTH-bit operands are added over WIDTH clock cycles, one bit per cycle, LSB first. Each bit is computed by a full-add stage built from two `half_adder` cells plus an OR. The block sits between a requester and the one-bit add datapath. It latches the operands on a start handshake, sequences the bits, holds the carry between cycles, and returns a registered sum and carry-out with a one-cycle done pulse.

## Interface
- `WIDTH`, 8, operand/sum width in bits; legal range 1..32.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when the block is idle or in the done cycle.
- `a`  in  WIDTH  operand A; sampled only on an accepted start.
- `b`  in  WIDTH  operand B; sampled only on an accepted start.
- `busy`  out  1  high while bits are being computed.
- `done`  out  1  one-cycle pulse; `sum` and `cout` are valid from this cycle.
- `sum`  out  WIDTH  result bits [WIDTH-1:0] of a+b.
- `cout`  out  1  carry out of bit WIDTH-1.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Transitions:
  - IDLE -> RUN on start=1.
  - RUN -> DONE at the edge that processes bit WIDTH-1, i.e. when cnt==WIDTH-1.
  - DONE -> RUN on start=1.
  - DONE -> IDLE otherwise.
- Accepted start, at that edge:
  - load shift registers sa<=a, sb<=b;
  - clear carry register c<=0;
  - clear bit counter cnt<=0;
  - clear the sum shift register.
- Each RUN edge:
  - full-add of sa[0], sb[0], c using two half adders: s=sa[0]^sb[0]^c, co=(sa[0]&sb[0])|((sa[0]^sb[0])&c);
  - c<=co;
  - shift s into the sum register from the MSB side, right shift;
  - shift sa and sb right by 1;
  - cnt<=cnt+1.
- On the last RUN edge, `cout` is loaded with co.
- Counter width is $clog2(WIDTH+1) bits. It never wraps in normal operation.
- Result holding:
  - `sum` and `cout` hold their value from the DONE cycle until the next accepted start.
  - They are not cleared by the DONE->IDLE transition.
  - During RUN, `sum` shows partial shift contents and is don't-care to consumers.
- Ignored inputs:
  - start during RUN is ignored; no restart and no queuing.
  - a and b changes outside an accepted-start edge have no effect.
- Equivalence: the result must equal (a+b) mod 2^WIDTH, with cout equal to bit WIDTH of a+b.

## Timing
- Reset: rst=1 at an edge forces IDLE with busy=0, done=0, sum=0, cout=0, c=0, cnt=0. Reset takes priority over start and over a RUN in progress.
- Reset mid-operation: the computation is abandoned and no done pulse is produced. The first start after rst deasserts is accepted normally.
- Latency: with start accepted at edge E0, busy=1 in cycles E0..E0+WIDTH-1 and done=1 for the single cycle after edge E0+WIDTH. Start-to-done is WIDTH+1 edges.
- Throughput: start held high in the DONE cycle begins the next operation at the following edge. Back-to-back operations therefore occur every WIDTH+1 cycles with no idle gap.
- WIDTH=1: RUN lasts one cycle and done follows at E0+2.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `serial_add_pkg`:
  - state enum {IDLE, RUN, DONE} as a 2-bit typedef;
  - localparam for the default WIDTH.
- Sub-module: the existing `half_adder` cell, instantiated twice to form the per-bit full-add stage. No new sub-module file.
- Remaining logic is one module: FSM, counter, operand/sum shift registers, carry flop.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start pulse -> busy high 8 cycles; done at E0+9 with sum=0x96, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1.
- a=0xFF, b=0xFF -> sum=0xFE, cout=1.
- Start with a=0x12, b=0x34, then in RUN cycle 3 pulse start with a=0xFF, b=0xFF -> second start ignored; sum=0x46, cout=0, exactly one done pulse.
- Start a=0x80, b=0x80, assert rst in RUN cycle 4 -> next edge gives busy=0, sum=0, cout=0, and no done. Then start a=0x01, b=0x02 -> sum=0x03.
- Two operations back to back, with start high in the DONE cycle: 0x10+0x20, then 0xF0+0x20 -> done pulses exactly 9 cycles apart; results 0x30/cout=0, then 0x10/cout=1.
- Random stimulus: 1000 operand pairs checked against a+b. Also rerun with WIDTH=1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/half_adder.sv
// One-bit half adder cell; two of these plus an OR form a full-add stage.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: latches operands on start, adds one bit per cycle
// LSB first, and returns a registered sum/carry-out with a one-cycle done pulse.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sb_q;
    logic [WIDTH-1:0] sum_next;
    logic [CW-1:0]    cnt_q;
    logic             c_q;
    logic             p, g, pc, s_bit, co;
    logic             last, accept;

    half_adder u_ha0 (
        .a (sa_q[0]),
        .b (sb_q[0]),
        .s (p),
        .c (g)
    );

    half_adder u_ha1 (
        .a (p),
        .b (c_q),
        .s (s_bit),
        .c (pc)
    );

    assign co     = g | pc;
    assign last   = (cnt_q == CW'(WIDTH - 1));
    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    // Sum fills from the MSB side so bit 0 lands in sum[0] after WIDTH shifts.
    always_comb begin
        sum_next            = sum >> 1;
        sum_next[WIDTH-1]   = s_bit;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa_q  <= '0;
            sb_q  <= '0;
            c_q   <= 1'b0;
            cnt_q <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            sa_q  <= a;
            sb_q  <= b;
            c_q   <= 1'b0;
            cnt_q <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state_q == RUN) begin
            sa_q  <= sa_q >> 1;
            sb_q  <= sb_q >> 1;
            c_q   <= co;
            cnt_q <= cnt_q + CW'(1);
            sum   <= sum_next;
            if (last) cout <= co;
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1 against a+b.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dones8 = 0;
    int last_done = 0;
    int prev_done = 0;
    int snap;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    // Pre-edge values: counts each done cycle of the 8-bit instance.
    always @(posedge clk) begin
        cyc++;
        if (done8 === 1'b1) begin
            dones8++;
            prev_done = last_done;
            last_done = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge; returns at the negedge inside the expected DONE cycle.
    // poke >= 0 raises start with other operands during that RUN cycle (0-based).
    task automatic op8(input logic [7:0] oa, input logic [7:0] ob, input int poke,
                       input string tag);
        logic [8:0] ref_sum;
        ref_sum = {1'b0, oa} + {1'b0, ob};
        start8 = 1'b1;
        a8     = oa;
        b8     = ob;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == poke) begin
                start8 = 1'b1;
                a8     = 8'hFF;
                b8     = 8'hFF;
            end else begin
                start8 = 1'b0;
                a8     = 8'($urandom);
                b8     = 8'($urandom);
            end
            chk({tag, "_busy"}, {31'b0, busy8}, 32'd1);
            @(negedge clk);
        end
        start8 = 1'b0;
        chk({tag, "_done"}, {31'b0, done8}, 32'd1);
        chk({tag, "_sum"},  {24'b0, sum8},  {24'b0, ref_sum[7:0]});
        chk({tag, "_cout"}, {31'b0, cout8}, {31'b0, ref_sum[8]});
    endtask

    task automatic op1(input logic oa, input logic ob, input string tag);
        logic [1:0] ref_sum;
        ref_sum = {1'b0, oa} + {1'b0, ob};
        start1 = 1'b1;
        a1     = oa;
        b1     = ob;
        @(negedge clk);
        start1 = 1'b0;
        a1     = 1'($urandom);
        b1     = 1'($urandom);
        chk({tag, "_busy"}, {31'b0, busy1}, 32'd1);
        @(negedge clk);
        chk({tag, "_done"}, {31'b0, done1}, 32'd1);
        chk({tag, "_sum"},  {31'b0, sum1},  {31'b0, ref_sum[0]});
        chk({tag, "_cout"}, {31'b0, cout1}, {31'b0, ref_sum[1]});
    endtask

    initial begin
        rst    = 1'b1;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy8}, 32'd0);
        chk("rst_done", {31'b0, done8}, 32'd0);
        chk("rst_sum",  {24'b0, sum8},  32'd0);
        chk("rst_cout", {31'b0, cout8}, 32'd0);
        chk("rst_busy1", {31'b0, busy1}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        op8(8'h5A, 8'h3C, -1, "d5a3c");
        @(negedge clk);
        chk("pulse_end", {31'b0, done8}, 32'd0);
        chk("hold_sum",  {24'b0, sum8},  32'h96);
        op8(8'hFF, 8'h01, -1, "dff01");
        @(negedge clk);
        op8(8'hFF, 8'hFF, -1, "dffff");
        @(negedge clk);

        // start during RUN must be ignored
        snap = dones8;
        op8(8'h12, 8'h34, 2, "ign");
        repeat (12) @(negedge clk);
        chk("ign_one_done", dones8 - snap, 32'd1);

        // reset in RUN cycle 4 abandons the operation
        snap   = dones8;
        start8 = 1'b1;
        a8     = 8'h80;
        b8     = 8'h80;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", {31'b0, busy8}, 32'd0);
        chk("mrst_done", {31'b0, done8}, 32'd0);
        chk("mrst_sum",  {24'b0, sum8},  32'd0);
        chk("mrst_cout", {31'b0, cout8}, 32'd0);
        repeat (12) @(negedge clk);
        chk("mrst_nodone", dones8 - snap, 32'd0);
        op8(8'h01, 8'h02, -1, "post_rst");
        @(negedge clk);

        // back to back: start held in the DONE cycle
        op8(8'h10, 8'h20, -1, "b2b0");
        op8(8'hF0, 8'h20, -1, "b2b1");
        @(negedge clk);
        chk("b2b_gap", last_done - prev_done, 32'd9);

        for (int n = 0; n < 1000; n++) begin
            op8(8'($urandom), 8'($urandom), -1, "rnd8");
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end
        @(negedge clk);

        op1(1'b1, 1'b1, "w1_11");
        @(negedge clk);
        chk("w1_pulse_end", {31'b0, done1}, 32'd0);
        op1(1'b1, 1'b0, "w1_10");
        for (int n = 0; n < 200; n++) begin
            op1(1'($urandom), 1'($urandom), "rnd1");
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
